// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: burst FSM state type and maximal-length tap masks
// for widths 4..16 (mask bit i feeds state bit i into the feedback XOR).
package lfsr_pkg;

   localparam int LFSR_REM_W = 9;

   typedef enum logic {
      BURST_IDLE = 1'b0,
      BURST_RUN  = 1'b1
   } burst_state_e;

   // Mask bit k corresponds to polynomial term x^(k+1) for a left-shifting register.
   function automatic logic [15:0] lfsr_taps(input int width);
      case (width)
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/status bundle of the LFSR generator; the master drives the controls.
interface lfsr_gen_if #(
   parameter int WIDTH = 8
);
   import lfsr_pkg::*;

   logic             LFSR_EN;
   logic             LOAD;
   logic [WIDTH-1:0] SEED_IN;
   logic             START;
   logic [7:0]       BURST_LEN;
   logic             BUSY;
   logic             DONE;
   logic             LFSR_BIT;
   logic [WIDTH-1:0] LFSR_STATE;
   logic             LFSR_PERIOD;
   logic [WIDTH-1:0] PERIOD_LEN;
   logic             MAXIMAL;
   burst_state_e     burst_state;

   // Burst handshake: START is accepted only while BUSY=0 (the DONE cycle included);
   // BUSY rises the cycle after acceptance and DONE pulses on the edge taking the last step.
   modport master (
      output LFSR_EN, LOAD, SEED_IN, START, BURST_LEN,
      input  BUSY, DONE, LFSR_BIT, LFSR_STATE, LFSR_PERIOD, PERIOD_LEN, MAXIMAL, burst_state
   );

   modport slave (
      input  LFSR_EN, LOAD, SEED_IN, START, BURST_LEN,
      output BUSY, DONE, LFSR_BIT, LFSR_STATE, LFSR_PERIOD, PERIOD_LEN, MAXIMAL, burst_state
   );

endinterface

// File: rtl/lfsr_burst_ctl.sv
// Burst FSM: counts a requested number of LFSR steps and flags the end of the burst.
module lfsr_burst_ctl
   import lfsr_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [7:0]   burst_len_i,
   input  logic         step_i,
   output logic         busy_o,
   output logic         done_o,
   output burst_state_e state_o
);

   burst_state_e            state_q;
   logic [LFSR_REM_W-1:0]   rem_q;
   logic                    busy_q;
   logic                    done_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= BURST_IDLE;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            BURST_IDLE: begin
               if (start_i) begin
                  state_q <= BURST_RUN;
                  busy_q  <= 1'b1;
                  // A length of zero encodes a full 256-step burst.
                  rem_q   <= (burst_len_i == 8'd0) ? 9'd256 : {1'b0, burst_len_i};
               end
            end
            BURST_RUN: begin
               if (step_i) begin
                  if (rem_q == 9'd1) begin
                     state_q <= BURST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     rem_q   <= '0;
                  end else begin
                     rem_q <= rem_q - 9'd1;
                  end
               end
            end
            default: begin
               state_q <= BURST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign state_o = state_q;

endmodule

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with free-run and burst stepping, seed load and period measurement.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH)),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic       CLK,
   input  logic       RESET,
   lfsr_gen_if.slave  bus
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] ref_q,   ref_d;
   logic [WIDTH-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] plen_q,  plen_d;
   logic             per_q,   per_d;

   logic             fb;
   logic             step;
   logic             busy;
   logic [WIDTH-1:0] next_state;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] cnt_inc;

   assign fb         = ^(state_q & TAPS);
   assign next_state = {state_q[WIDTH-2:0], fb};
   assign load_val   = (bus.SEED_IN == '0) ? SEED : bus.SEED_IN;
   assign step       = !bus.LOAD && (bus.LFSR_EN || busy);
   assign cnt_inc    = cnt_q + WIDTH'(1);

   lfsr_burst_ctl u_burst_ctl (
      .clk_i       (CLK),
      .rst_ni      (RESET),
      .start_i     (bus.START),
      .burst_len_i (bus.BURST_LEN),
      .step_i      (step),
      .busy_o      (busy),
      .done_o      (bus.DONE),
      .state_o     (bus.burst_state)
   );

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      cnt_d   = cnt_q;
      plen_d  = plen_q;
      per_d   = 1'b0;
      if (bus.LOAD) begin
         state_d = load_val;
         ref_d   = load_val;
         cnt_d   = '0;
      end else if (step) begin
         state_d = next_state;
         // A saturated counter means the reference was never revisited; freeze measurement.
         if (cnt_q != CNT_MAX) begin
            if (next_state == ref_q) begin
               plen_d = cnt_inc;
               cnt_d  = '0;
               per_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_MAX) begin
                  plen_d = '0;
               end
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= SEED;
         ref_q   <= SEED;
         cnt_q   <= '0;
         plen_q  <= '0;
         per_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         cnt_q   <= cnt_d;
         plen_q  <= plen_d;
         per_q   <= per_d;
      end
   end

   assign bus.BUSY        = busy;
   assign bus.LFSR_BIT    = state_q[WIDTH-1];
   assign bus.LFSR_STATE  = state_q;
   assign bus.LFSR_PERIOD = per_q;
   assign bus.PERIOD_LEN  = plen_q;
   assign bus.MAXIMAL     = (plen_q == CNT_MAX);

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning LFSR state width (legal 4..16).
REQ-002 SHALL have parameter TAPS, default 8'hB8, WIDTH bits, meaning feedback mask (bit i set = state bit i XORed into feedback).
REQ-003 SHALL have parameter SEED, default 8'h01, WIDTH bits, nonzero, meaning reset state.
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port LFSR_EN  input  1  free-run step enable.
REQ-007 SHALL have port LOAD  input  1  synchronous seed load strobe.
REQ-008 SHALL have port SEED_IN  input  WIDTH  seed value for LOAD.
REQ-009 SHALL have port START  input  1  burst request.
REQ-010 SHALL have port BURST_LEN  input  8  burst step count; 0 means 256.
REQ-011 SHALL have port BUSY  output  1  burst in progress.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse at burst end.
REQ-013 SHALL have port LFSR_BIT  output  1  serial output, equal to state MSB.
REQ-014 SHALL have port LFSR_STATE  output  WIDTH  current state register.
REQ-015 SHALL have port LFSR_PERIOD  output  1  one-cycle pulse when state returns to reference.
REQ-016 SHALL have port PERIOD_LEN  output  WIDTH  last measured period in steps.
REQ-017 SHALL have port MAXIMAL  output  1  high when PERIOD_LEN equals 2^WIDTH-1.

Function
REQ-018 A step SHALL set state to {state[WIDTH-2:0], fb}, fb = XOR-reduce(state & TAPS).
REQ-019 A step SHALL occur in a cycle iff LOAD=0 and (LFSR_EN=1 or FSM in RUN).
REQ-020 LOAD=1 SHALL override stepping: state and reference <= SEED_IN (SEED if SEED_IN=0), step counter <= 0, PERIOD_LEN unchanged.
REQ-021 FSM SHALL have states IDLE and RUN; IDLE->RUN on START=1, latching BURST_LEN into a 9-bit remaining counter (0 -> 256).
REQ-022 In RUN, each step SHALL decrement remaining; when remaining reaches 1 and a step occurs, FSM SHALL return to IDLE and DONE SHALL pulse that same edge (registered, one cycle).
REQ-023 A LOAD during RUN SHALL suppress that cycle's step and not decrement remaining; the burst continues.
REQ-024 START while BUSY=1 SHALL be ignored; START in the DONE cycle SHALL start a new burst.
REQ-025 BUSY SHALL be registered and high exactly in RUN; burst of N steps gives BUSY high N cycles absent LOAD.
REQ-026 Step counter (WIDTH bits) SHALL increment per step; when a step produces state == reference, PERIOD_LEN <= counter+1, counter <= 0, LFSR_PERIOD pulses next cycle (registered).
REQ-027 If the counter reaches 2^WIDTH-1 without return, PERIOD_LEN SHALL be set to 0 and counter SHALL hold until LOAD or reset.
REQ-028 MAXIMAL SHALL be combinational from PERIOD_LEN.

Reset
REQ-029 RESET=0 SHALL asynchronously set state=SEED, reference=SEED, counter=0, PERIOD_LEN=0, FSM=IDLE, BUSY=0, DONE=0, LFSR_PERIOD=0.
REQ-030 Reset mid-burst SHALL abort the burst with no DONE pulse.
REQ-031 Reset release SHALL be synchronised upstream; the block performs no internal resynchronisation.

Structure
REQ-032 Tap constants for widths 4..16 (maximal polynomials) SHALL live in shared package lfsr_pkg.
REQ-033 Burst FSM SHALL be sub-module lfsr_burst_ctl; state, counter and period logic stay in lfsr_gen.
REQ-034 Instantiated with WIDTH=8, TAPS=8'hB8, SEED=8'h01 it SHALL replace LFSR8 in the top level.

Verification
REQ-035 WIDTH=8, reset, LFSR_EN=1 for 260 cycles -> LFSR_PERIOD pulses once after step 255, PERIOD_LEN=255, MAXIMAL=1.
REQ-036 Reset, LFSR_EN=0, START with BURST_LEN=5 -> BUSY high 5 cycles, DONE one pulse, LFSR_STATE = 8'h01 stepped 5 times.
REQ-037 BURST_LEN=0 -> BUSY high 256 cycles, LFSR_PERIOD pulses once during burst.
REQ-038 LOAD with SEED_IN=0 mid-burst of 10 -> state=8'h01, burst still totals 10 steps, BUSY 11 cycles.
REQ-039 Non-maximal TAPS=8'h82 -> PERIOD_LEN != 255, MAXIMAL=0; RESET low mid-burst -> BUSY=0 immediately, no DONE.
